// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux + register file; inputs wb_* (MEM/WB), rs1/rs2_addr, dbg_addr; outputs rs1/rs2_data (comb, bypassed), wb_data (comb), dbg_data (registered), wb_count (saturating)
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wb_count
);
  localparam int N = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [N];
  logic commit;
  logic byp;
  assign wb_data  = wb_mem_to_reg ? wb_read_data : wb_alu_result;
  assign commit   = wb_reg_write && wb_write_reg != '0;
  assign byp      = rst_n && commit;
  assign rs1_data = rs1_addr == '0 ? '0 : (byp && wb_write_reg == rs1_addr) ? wb_data : regs[rs1_addr];
  assign rs2_data = rs2_addr == '0 ? '0 : (byp && wb_write_reg == rs2_addr) ? wb_data : regs[rs2_addr];
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      dbg_data <= '0;
      wb_count <= '0;
    end else begin
      if (commit) regs[wb_write_reg] <= wb_data;
      dbg_data <= dbg_addr == '0 ? '0 : regs[dbg_addr];
      if (commit && wb_count != '1) wb_count <= wb_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed + random check of wb_regfile against an array/counter model
module tb_wb_regfile;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, wr, m2r;
  logic [15:0] alu, rd;
  logic [2:0] dst, a1, a2, da;
  logic [15:0] r1, r2, wd, dd, cnt, r1s, r2s, wds, dds;
  logic [2:0] cnt_s;
  logic [15:0] m [8] = '{default: 16'h0};
  logic [15:0] dbg_m = 16'h0;
  int cnt_m = 0, cnts_m = 0;
  int n_assert = 0, n_fail = 0;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_reg_write(wr), .wb_mem_to_reg(m2r),
    .wb_alu_result(alu), .wb_read_data(rd), .wb_write_reg(dst),
    .rs1_addr(a1), .rs2_addr(a2), .rs1_data(r1), .rs2_data(r2),
    .wb_data(wd), .dbg_addr(da), .dbg_data(dd), .wb_count(cnt)
  );
  wb_regfile #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .wb_reg_write(wr), .wb_mem_to_reg(m2r),
    .wb_alu_result(alu), .wb_read_data(rd), .wb_write_reg(dst),
    .rs1_addr(a1), .rs2_addr(a2), .rs1_data(r1s), .rs2_data(r2s),
    .wb_data(wds), .dbg_addr(da), .dbg_data(dds), .wb_count(cnt_s)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sel();
    return m2r ? rd : alu;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (rst_n && wr && dst == a) return sel();
    return m[a];
  endfunction

  task automatic set(input logic w, input logic mr, input logic [15:0] al,
                     input logic [15:0] rdd, input logic [2:0] ds);
    wr = w; m2r = mr; alu = al; rd = rdd; dst = ds;
  endtask

  task automatic comb_chk();
    chk("rs1", r1, exp_rd(a1));
    chk("rs2", r2, exp_rd(a2));
    chk("wb_data", wd, sel());
    chk("rs1_s", r1s, exp_rd(a1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      foreach (m[i]) m[i] = 16'h0;
      dbg_m = 16'h0; cnt_m = 0; cnts_m = 0;
    end else begin
      dbg_m = (da == 3'd0) ? 16'h0 : m[da];
      if (wr && dst != 3'd0) begin
        m[dst] = sel();
        if (cnt_m < 65535) cnt_m++;
        if (cnts_m < 7) cnts_m++;
      end
    end
    #1;
    chk("dbg_data", dd, dbg_m);
    chk("wb_count", cnt, 16'(cnt_m));
    chk("wb_count_s", {13'b0, cnt_s}, 16'(cnts_m));
  endtask

  initial begin
    rst_n = 1'b0; a1 = 3'd3; a2 = 3'd0; da = 3'd0;
    set(1'b1, 1'b0, 16'hBEEF, 16'h0, 3'd3);
    tick();
    #1 chk("rst_rs1_no_bypass", r1, 16'h0);
    tick();
    rst_n = 1'b1; wr = 1'b0;
    #1 chk("rst_rs1", r1, 16'h0);
    chk("rst_cnt", cnt, 16'h0);
    chk("rst_dbg", dd, 16'h0);

    set(1'b1, 1'b0, 16'h1234, 16'h0, 3'd2);
    #1 comb_chk();
    tick();
    set(1'b1, 1'b1, 16'hFFFF, 16'hA5A5, 3'd5);
    #1 chk("mux_mem", wd, 16'hA5A5);
    tick();
    wr = 1'b0; a1 = 3'd2; a2 = 3'd5;
    #1 chk("r2", r1, 16'h1234);
    chk("r5", r2, 16'hA5A5);
    chk("cnt2", cnt, 16'd2);

    set(1'b1, 1'b0, 16'h0001, 16'h0, 3'd4);
    tick();
    set(1'b1, 1'b0, 16'h00FF, 16'h0, 3'd4);
    a1 = 3'd4; a2 = 3'd4; da = 3'd4;
    #1 chk("byp_rs1", r1, 16'h00FF);
    chk("byp_rs2", r2, 16'h00FF);
    tick();
    chk("dbg_prewrite", dd, 16'h0001);
    wr = 1'b0;
    #1 chk("r4_after", r1, 16'h00FF);

    set(1'b1, 1'b0, 16'hDEAD, 16'h0, 3'd0);
    a1 = 3'd0;
    #1 chk("r0_before", r1, 16'h0);
    chk("r0_wbdata", wd, 16'hDEAD);
    tick();
    chk("r0_after", r1, 16'h0);
    chk("r0_cnt", cnt, 16'd4);

    set(1'b0, 1'b0, 16'h7777, 16'h0, 3'd6);
    a2 = 3'd6;
    #1 chk("en_low_rs2", r2, 16'h0);
    chk("en_low_wbdata", wd, 16'h7777);
    tick();
    chk("en_low_r6", r2, 16'h0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      set(1'b1, 1'b0, 16'(i), 16'h0, 3'(1 + (i % 7)));
      tick();
      chk("sat", {13'b0, cnt_s}, 16'((i > 7) ? 7 : i));
    end

    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      set(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
      a1 = 3'($urandom); a2 = ($urandom_range(0, 2) == 0) ? dst : 3'($urandom);
      da = 3'($urandom);
      #1 comb_chk();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (ALU result or memory load data) and commits it to the 8 x 16-bit architectural register file.
- Provides two combinational read ports to ID, with same-cycle write-to-read bypass, plus a debug read port and a retired-write counter for verification.

Parameters:
- DATA_W, 16, register/data width
- ADDR_W, 3, register index width (2^ADDR_W registers)
- CNT_W, 16, width of retired-write counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- wb_reg_write  input  1  writeback enable from MEM/WB register
- wb_mem_to_reg  input  1  1 = write wb_read_data, 0 = write wb_alu_result
- wb_alu_result  input  DATA_W  ALU result from MEM/WB
- wb_read_data  input  DATA_W  load data from MEM/WB
- wb_write_reg  input  ADDR_W  destination register index
- rs1_addr  input  ADDR_W  read port 1 index (ID stage)
- rs2_addr  input  ADDR_W  read port 2 index (ID stage)
- rs1_data  output  DATA_W  read port 1 data, combinational
- rs2_data  output  DATA_W  read port 2 data, combinational
- wb_data  output  DATA_W  selected writeback value, combinational (for forwarding unit)
- dbg_addr  input  ADDR_W  debug read index
- dbg_data  output  DATA_W  debug read data, registered (1-cycle latency)
- wb_count  output  CNT_W  number of committed writes since reset, saturating

Behaviour:
- Reset: when rst_n = 0 at a rising clk edge, all 8 registers clear to 0, dbg_data <= 0, and wb_count <= 0. rst_n has no asynchronous effect. While rst_n = 0, no write commits, even if wb_reg_write = 1.
- Writeback mux: wb_data = wb_mem_to_reg ? wb_read_data : wb_alu_result. Purely combinational and independent of wb_reg_write.
- Commit: on a rising edge with rst_n = 1, wb_reg_write = 1, and wb_write_reg != 0, reg[wb_write_reg] <= wb_data.
- R0: hardwired zero. Writes to index 0 are discarded, and reads of index 0 always return 0 (storage may exist but is never observable).
- Read ports: rsN_data = (rsN_addr == 0) ? 0 : bypass_hit ? wb_data : reg[rsN_addr].
  - bypass_hit = wb_reg_write and (wb_write_reg == rsN_addr) and (rsN_addr != 0). The bypass gives the value written this cycle, so ID sees it without waiting an extra cycle.
  - While rst_n = 0, read ports still behave combinationally. The bypass is suppressed (bypass_hit gated by rst_n), so reads return stored data.
- Debug port: dbg_data <= (dbg_addr == 0) ? 0 : reg[dbg_addr], sampled at the edge. This is the pre-write value if the same register is written that edge. No bypass.
- Counter: wb_count increments by 1 on each committed write (an R0 write is not a commit). It holds at 2^CNT_W - 1 and does not wrap.
- Simultaneous events:
  - Both read ports may address the same register as each other and as the write target; all hits return wb_data.
  - Reset asserted while wb_reg_write = 1: reset wins and the register stays 0.
- No X propagation: every output is defined from the first edge with rst_n = 0.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with wb_reg_write = 1, wb_write_reg = 3, wb_alu_result = 16'hBEEF -> after release, rs1_addr = 3 gives 0, wb_count = 0, dbg_data = 0.
- Mux and commit: write r2 with mem_to_reg = 0 and alu = 16'h1234, then r5 with mem_to_reg = 1 and read_data = 16'hA5A5, alu = 16'hFFFF -> subsequent reads give r2 = 16'h1234, r5 = 16'hA5A5, wb_count = 2.
- Bypass: r4 holds 16'h0001; in the same cycle write r4 = 16'h00FF with rs1_addr = rs2_addr = 4 -> both read 16'h00FF combinationally before the edge, and 16'h00FF persists after it. dbg_addr = 4 that edge captures 16'h0001.
- R0: write index 0 with 16'hDEAD -> rs1_data(0) = 0 both before and after the edge, no bypass, wb_count unchanged.
- Enable low: wb_reg_write = 0, wb_write_reg = 6, alu = 16'h7777 -> r6 unchanged, no bypass on rs2_addr = 6, wb_data = 16'h7777.
- Saturation (CNT_W = 3 override): perform 9 committed writes -> wb_count reaches 7 and stays at 7.
